booth_mult_seq: RTL and testbench

//  Sequential radix-2 Booth signed multiplier that feeds MIPS MULT results (HI/LO) into the pipeline.

---
 rtl/mips_mult_pkg.sv | 21 ++
 rtl/booth_addsub.sv | 23 ++
 rtl/booth_mult_seq.sv | 149 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mult_pkg.sv
// Shared constants for the sequential Booth multiplier: Booth step codes and FSM encodings.
package mips_mult_pkg;

  localparam int unsigned MULT_WIDTH = 16;

  // Booth step selector {Q[0], Q_1}
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Maps the two multiplier bits under inspection onto a Booth step code
  function automatic logic [1:0] booth_sel(input logic q0, input logic q_1);
    booth_sel = {q0, q_1};
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational add / subtract / pass-through used by each Booth step.
module booth_addsub
  import mips_mult_pkg::*;
#(
  parameter int unsigned W = MULT_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] sum_c
);

  // Select A+M, A-M or A according to the Booth code; 11 behaves as 00
  always_comb begin
    sum_c = a;
    case (op)
      BOOTH_ADD: sum_c = a + b;
      BOOTH_SUB: sum_c = a - b;
      default:   sum_c = a;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier with start/done handshake and pipeline flush.
module booth_mult_seq
  import mips_mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned AW    = WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,   state_d;
  logic [AW-1:0]      a_q,       a_d;
  logic [WIDTH-1:0]   q_q,       q_d;
  logic               q1_q,      q1_d;
  logic [WIDTH-1:0]   m_q,       m_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [1:0]         booth_op;
  logic [AW-1:0]      m_ext;
  logic [AW-1:0]      a_sum;
  logic [AW-1:0]      a_shift;
  logic [WIDTH-1:0]   q_shift;
  logic               q1_shift;

  assign booth_op = booth_sel(q_q[0], q1_q);
  assign m_ext    = {m_q[WIDTH-1], m_q};

  booth_addsub #(
    .W (AW)
  ) u_addsub (
    .a     (a_q),
    .b     (m_ext),
    .op    (booth_op),
    .sum_c (a_sum)
  );

  // Arithmetic right shift of {A', Q, Q_1}; sign comes from the updated accumulator
  always_comb begin
    a_shift  = {a_sum[AW-1], a_sum[AW-1:1]};
    q_shift  = {a_sum[0], q_q[WIDTH-1:1]};
    q1_shift = q_q[0];
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;
    busy_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = '0;
          q_d     = multiplier;
          q1_d    = 1'b0;
          m_d     = multiplicand;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_d  = a_shift;
        q_d  = q_shift;
        q1_d = q1_shift;
        if (cnt_q == LAST_STEP) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          product_d = {a_shift[WIDTH-1:0], q_shift};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = '0;
          q_d     = multiplier;
          q1_d    = 1'b0;
          m_d     = multiplicand;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush overrides everything, including a concurrent start; last product is kept
    if (flush) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      product_d = product_q;
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks for booth_mult_seq; inputs driven and outputs sampled on the falling edge.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks;
  int n_fail;

  booth_mult_seq #(
    .WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Start a multiply in the current cycle, scramble operands afterwards, wait for done
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
    int cyc;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = b ^ 16'h5A5A;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " latency"}, 32'(cyc), 32'd17);
    check_eq({tag, " product"}, product, exp);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          sa;
    int          sb;
    bit          seen_done;

    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    flush        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3 x 5 with cycle-by-cycle busy/done profile
    multiplicand = 16'd3;
    multiplier   = 16'd5;
    start        = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq($sformatf("t1 busy c%0d", k), 32'(busy), (k <= 16) ? 32'd1 : 32'd0);
      check_eq($sformatf("t1 done c%0d", k), 32'(done), (k == 17) ? 32'd1 : 32'd0);
      if (k == 17) check_eq("t1 product", product, 32'h0000_000F);
    end

    // Signed corner cases
    do_mul("neg7x6", 16'(-7), 16'd6, 32'hFFFF_FFD6);
    do_mul("0xm1", 16'd0, 16'hFFFF, 32'h0000_0000);
    do_mul("minxmin", 16'h8000, 16'h8000, 32'h4000_0000);
    do_mul("maxxmin", 16'h7FFF, 16'h8000, 32'hC000_8000);

    // Back-to-back with ignored start pulses at cycles 5 and 20
    @(negedge clk);
    multiplicand = 16'd7;
    multiplier   = 16'(-3);
    start        = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5 || k == 20) begin
        multiplicand = 16'd100;
        multiplier   = 16'd100;
        start        = 1'b1;
      end
      if (k == 17) begin
        check_eq("b2b first done", 32'(done), 32'd1);
        check_eq("b2b first product", product, 32'hFFFF_FFEB);
        multiplicand = 16'd2;
        multiplier   = 16'd2;
        start        = 1'b1;
      end
      if (k == 18) check_eq("b2b busy c18", 32'(busy), 32'd1);
      if (k == 33) check_eq("b2b no early done", 32'(done), 32'd0);
      if (k == 34) begin
        check_eq("b2b second done", 32'(done), 32'd1);
        check_eq("b2b second product", product, 32'd4);
      end
      if (k == 35) begin
        check_eq("b2b idle busy", 32'(busy), 32'd0);
        check_eq("b2b idle done", 32'(done), 32'd0);
      end
    end

    // Flush mid-operation keeps the previous product
    do_mul("pre flush 3x5", 16'd3, 16'd5, 32'h0000_000F);
    @(negedge clk);
    multiplicand = 16'd9;
    multiplier   = 16'd9;
    start        = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (k == 8);
    end
    check_eq("flush busy c9", 32'(busy), 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check_eq("flush no done", 32'(seen_done), 32'd0);
    check_eq("flush product kept", product, 32'h0000_000F);

    // Flush and start together in IDLE: start dropped
    multiplicand = 16'd4;
    multiplier   = 16'd4;
    flush        = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check_eq("flush+start busy", 32'(busy), 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check_eq("flush+start stays idle", 32'(seen_done), 32'd0);

    // Reset in cycle 10 of an operation, then a clean multiply
    multiplicand = 16'd1000;
    multiplier   = 16'd1000;
    start        = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = (k == 10);
    end
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst product", product, 32'd0);
    do_mul("post rst", 16'd1234, 16'(-5678), 32'hFF95_1644);

    // Random scoreboard against a signed reference
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      sa = $signed(ra);
      sb = $signed(rb);
      do_mul($sformatf("rand%0d", i), ra, rb, 32'(sa * sb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
